// File: rtl/prio4_pkg.sv
// rtl/prio4_pkg.sv - shared types, FSM encoding and one-hot decode for the prio4 grant path
package prio4_pkg;

    localparam int PRIO_N = 4;
    localparam int IDX_W  = 2;

    typedef struct packed {
        logic             none;
        logic [IDX_W-1:0] idx;
    } prio_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } prio_state_t;

    function automatic logic [PRIO_N-1:0] prio_decode(input prio_entry_t entry);
        logic [PRIO_N-1:0] onehot;
        onehot = '0;
        if (!entry.none) begin
            onehot[entry.idx] = 1'b1;
        end
        return onehot;
    endfunction

endpackage

// File: rtl/prio_sync_fifo.sv
// rtl/prio_sync_fifo.sv - synchronous FIFO of encoded grant entries with occupancy count
module prio_sync_fifo
    import prio4_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  prio_entry_t            push_data,
    input  logic                   pop,
    output prio_entry_t            pop_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);

    prio_entry_t      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   level_nxt;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_comb begin
        level_nxt = level;
        if (do_push && !do_pop) begin
            level_nxt = level + (PTR_W+1)'(1);
        end else if (do_pop && !do_push) begin
            level_nxt = level - (PTR_W+1)'(1);
        end
    end

    // full/empty are registered so in_ready never sees a combinational path
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level <= level_nxt;
            full  <= (level_nxt == (PTR_W+1)'(DEPTH));
            empty <= (level_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/prio4_grant_decoder.sv
// rtl/prio4_grant_decoder.sv - buffers encoded requests and presents one-hot grants with optional idle gap
module prio4_grant_decoder
    import prio4_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int GAP   = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [IDX_W-1:0]       in_value,
    input  logic                   in_none,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [PRIO_N-1:0]      out_onehot,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] level
);

    localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    prio_state_t state;
    prio_state_t state_nxt;
    prio_entry_t push_data;
    prio_entry_t head;
    logic [3:0]  gap_cnt;
    logic        fifo_full;
    logic        fifo_empty;
    logic        pop;

    assign push_data = '{none: in_none, idx: in_value};
    assign in_ready  = !fifo_full;

    prio_sync_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (in_valid),
        .push_data(push_data),
        .pop      (pop),
        .pop_data (head),
        .level    (level),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (!fifo_empty) state_nxt = ST_GRANT;
            ST_GRANT: if (out_ready) state_nxt = (GAP > 0) ? ST_GAP : ST_IDLE;
            ST_GAP:   if (gap_cnt == GAP_LAST) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        pop = 1'b0;
        if (state == ST_IDLE && !fifo_empty) begin
            pop = 1'b1;
        end
    end

    // gap_cnt is zero on entry to GAP because it clears in every other state
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_onehot <= '0;
            gap_cnt    <= '0;
        end else begin
            out_valid <= (state_nxt == ST_GRANT);
            if (pop) begin
                out_onehot <= prio_decode(head);
            end
            if (state == ST_GAP) begin
                gap_cnt <= gap_cnt + 4'd1;
            end else begin
                gap_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_prio4_grant_decoder.sv
// tb/tb_prio4_grant_decoder.sv - model-checked randomized bench for prio4_grant_decoder (GAP=0 and GAP=3)
module tb_prio4_grant_decoder;

    localparam int DEPTH = 4;
    localparam int NI    = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [1:0] in_value;
    logic       in_none;
    logic       out_ready;

    logic       in_ready_w  [NI];
    logic       out_valid_w [NI];
    logic [3:0] onehot_w    [NI];
    logic [2:0] level_w     [NI];

    prio4_grant_decoder #(.DEPTH(DEPTH), .GAP(0)) u_g0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_value(in_value), .in_none(in_none),
        .in_ready(in_ready_w[0]), .out_valid(out_valid_w[0]), .out_onehot(onehot_w[0]),
        .out_ready(out_ready), .level(level_w[0])
    );

    prio4_grant_decoder #(.DEPTH(DEPTH), .GAP(3)) u_g3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_value(in_value), .in_none(in_none),
        .in_ready(in_ready_w[1]), .out_valid(out_valid_w[1]), .out_onehot(onehot_w[1]),
        .out_ready(out_ready), .level(level_w[1])
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    function automatic int gap_of(input int k);
        return (k == 0) ? 0 : 3;
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %0h, expected %0h (cycle %0d)", name, k, act, exp, cyc);
        end
    endtask

    // Model: a queue of pending entries, a held grant, and a count of edges before the next pop
    logic [2:0] mq      [NI][$];
    bit         m_hold  [NI];
    logic [3:0] m_grant [NI];
    int         m_block [NI];
    bit         m_live = 1'b0;

    logic [3:0] obs     [NI][$];
    int         obs_cyc [NI][$];

    initial begin
        bit         accept;
        logic [2:0] head;
        forever begin
            @(posedge clk);
            cyc++;
            for (int k = 0; k < NI; k++) begin
                if (rst) begin
                    mq[k].delete();
                    m_hold[k]  = 1'b0;
                    m_grant[k] = 4'b0000;
                    m_block[k] = 0;
                end else begin
                    accept = in_valid && (mq[k].size() < DEPTH);
                    if (m_hold[k]) begin
                        if (out_ready) begin
                            m_hold[k]  = 1'b0;
                            m_block[k] = gap_of(k);
                        end
                    end else if (m_block[k] > 0) begin
                        m_block[k]--;
                    end else if (mq[k].size() > 0) begin
                        head       = mq[k].pop_front();
                        m_hold[k]  = 1'b1;
                        m_grant[k] = head[2] ? 4'b0000 : 4'(1 << head[1:0]);
                    end
                    if (accept) mq[k].push_back({in_none, in_value});
                end
            end
            if (rst) m_live = 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_live) begin
                for (int k = 0; k < NI; k++) begin
                    chk("out_valid", k, out_valid_w[k], m_hold[k]);
                    chk("level", k, level_w[k], mq[k].size());
                    chk("in_ready", k, in_ready_w[k], mq[k].size() < DEPTH);
                    if (m_hold[k]) chk("out_onehot", k, onehot_w[k], m_grant[k]);
                    if (out_valid_w[k] && out_ready && !rst) begin
                        obs[k].push_back(onehot_w[k]);
                        obs_cyc[k].push_back(cyc);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit none, input logic [1:0] v);
        in_valid = 1'b1;
        in_none  = none;
        in_value = v;
        step();
        in_valid = 1'b0;
    endtask

    task automatic clear_obs();
        for (int k = 0; k < NI; k++) begin
            obs[k].delete();
            obs_cyc[k].delete();
        end
    endtask

    logic [3:0] exp_sweep [5];
    logic [3:0] exp_bp    [5];
    bit         stale;

    initial begin
        exp_sweep = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
        exp_bp    = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst = 1'b1; in_valid = 1'b0; in_value = 2'd0; in_none = 1'b0; out_ready = 1'b0;
        step(); step();
        rst = 1'b0;

        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk("rst_out_valid", k, out_valid_w[k], 1'b0);
            chk("rst_onehot", k, onehot_w[k], 4'b0000);
            chk("rst_level", k, level_w[k], 3'd0);
            chk("rst_in_ready", k, in_ready_w[k], 1'b1);
        end

        step();
        push(1'b0, 2'd2);
        step();
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk("single_valid", k, out_valid_w[k], 1'b1);
            chk("single_onehot", k, onehot_w[k], 4'b0100);
        end
        step();
        out_ready = 1'b1;
        step();
        @(negedge clk);
        chk("single_drop", 0, out_valid_w[0], 1'b0);
        step();
        repeat (10) step();

        // Sweep every index plus the no-request code with downstream always ready
        clear_obs();
        push(1'b0, 2'd0); push(1'b0, 2'd1); push(1'b0, 2'd2); push(1'b0, 2'd3); push(1'b1, 2'd0);
        repeat (40) step();
        for (int k = 0; k < NI; k++) begin
            chk("sweep_count", k, obs[k].size(), 5);
            if (obs[k].size() == 5) begin
                for (int i = 0; i < 5; i++) chk("sweep_grant", k, obs[k][i], exp_sweep[i]);
                for (int i = 0; i < 4; i++)
                    chk("sweep_spacing", k, obs_cyc[k][i+1] - obs_cyc[k][i], (k == 0) ? 2 : 5);
            end
        end

        // Backpressure: DEPTH+2 pushes, only one in GRANT plus DEPTH queued are taken
        out_ready = 1'b0;
        clear_obs();
        for (int i = 0; i < DEPTH + 2; i++) push(1'b0, 2'(i % 4));
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk("bp_level", k, level_w[k], 3'd4);
            chk("bp_in_ready", k, in_ready_w[k], 1'b0);
            chk("bp_valid", k, out_valid_w[k], 1'b1);
            chk("bp_onehot", k, onehot_w[k], 4'b0001);
        end
        step();
        out_ready = 1'b1;
        repeat (60) step();
        for (int k = 0; k < NI; k++) begin
            chk("bp_count", k, obs[k].size(), 5);
            if (obs[k].size() == 5)
                for (int i = 0; i < 5; i++) chk("bp_grant", k, obs[k][i], exp_bp[i]);
        end

        // Simultaneous push and pop at level 3 on the GAP=0 instance
        out_ready = 1'b0;
        push(1'b0, 2'd3); push(1'b0, 2'd2); push(1'b0, 2'd1); push(1'b0, 2'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        in_valid = 1'b1; in_none = 1'b0; in_value = 2'd3;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("pushpop_level", 0, level_w[0], 3'd3);
        chk("pushpop_valid", 0, out_valid_w[0], 1'b1);
        step();
        out_ready = 1'b1;
        repeat (60) step();

        // Randomized traffic with occasional resets
        for (int i = 0; i < 2500; i++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            in_value  = 2'($urandom_range(0, 3));
            in_none   = ($urandom_range(0, 7) == 0);
            out_ready = (i < 1200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (40) step();

        // Reset while the GAP=0 instance holds a grant with three entries queued
        out_ready = 1'b0;
        push(1'b0, 2'd1); push(1'b0, 2'd2); push(1'b0, 2'd3); push(1'b0, 2'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk("midrst_valid", k, out_valid_w[k], 1'b0);
            chk("midrst_level", k, level_w[k], 3'd0);
        end
        out_ready = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            @(negedge clk);
            if (out_valid_w[0] || out_valid_w[1]) stale = 1'b1;
        end
        chk("midrst_no_stale", 0, stale, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prio4_grant_decoder.md
# prio4_grant_decoder

Decoding end of the 4-input priority encoder path. It accepts a stream of encoded 2-bit request indices, each with a "no request" flag, and buffers them in a small FIFO. It re-expands each entry into a one-hot 4-bit grant and presents it downstream under a valid/ready handshake, with an optional idle gap between grants for switch-setting logic to settle. It sits between the priority encoder and the per-port enable lines of the switch fabric.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `GAP`, default 0: idle cycles forced after each completed grant; 0 to 15.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: encoded entry present.
- `in_value` in 2: encoded index, 0 to 3.
- `in_none` in 1: encoder saw no request; decodes to 4'b0000.
- `in_ready` out 1: FIFO can accept this cycle.
- `out_valid` out 1: grant presented.
- `out_onehot` out 4: decoded grant; bit `in_value` set, or all zero if `in_none`.
- `out_ready` in 1: downstream accepts the grant.
- `level` out $clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- **Push:** when `in_valid && in_ready`, {in_none, in_value} is written at the tail.
- **`in_ready`:** equals `level < DEPTH`. It is registered-state only and never depends on `out_ready`.
- **Decode:** `out_onehot = in_none ? 4'b0000 : (4'b0001 << in_value)`. Applied when an entry leaves the FIFO into the output register.
- **Output FSM:**
  - IDLE: if the FIFO is non-empty, pop the head into the output register and go to GRANT.
  - GRANT: `out_valid`=1; `out_onehot` holds stable. On `out_ready`, go to GAP if GAP>0, else IDLE.
  - GAP: `out_valid`=0; count GAP cycles, then go to IDLE.
- **Back-to-back:** with GAP=0, IDLE lasts exactly one cycle between grants. Sustained throughput is one grant per 2 cycles.
- **Simultaneous push and pop:** both happen; `level` is unchanged. There is no bypass from input to output register when the FIFO is empty.
- **Push when full:** impossible by construction, because `in_ready`=0. `in_valid` with `in_ready`=0 is ignored with no side effect.
- **Pointers:** wrap modulo DEPTH.
- **`level`:** counts 0..DEPTH with no wrap.
- **Dropped grant:** `out_ready` while `out_valid`=0 has no effect.
- **Reset** (any time, including mid-GRANT or mid-GAP):
  - pointers, `level`, and GAP counter go to 0;
  - FSM goes to IDLE;
  - `out_valid`=0, `out_onehot`=4'b0000, `level`=0;
  - `in_ready` is 1 in the first cycle after reset.
  - In-flight entries are discarded.

## Timing
- **Latency into an empty, idle block:** entry accepted at edge E0, popped at edge E1, `out_valid`/`out_onehot` visible after E1.
- **Holding:** `out_onehot` and `out_valid` stay stable from entering GRANT until the handshake edge.
- **Gap spacing:** after a handshake at edge H, `out_valid` is 0 for GAP+1 cycles; the next grant appears after edge H+GAP+1 if the FIFO is non-empty.
- **`in_ready` after a pop:** rises the cycle after a pop frees a full FIFO.
- All outputs are driven from registers.

## Structure
- Shared package `prio4_pkg`:
  - `PRIO_N=4`, `IDX_W=2`;
  - typedef `prio_entry_t` = {none, idx[1:0]};
  - FSM enum {IDLE, GRANT, GAP};
  - function `prio_decode(entry)` returning 4-bit one-hot.
- Sub-module `prio_sync_fifo` (parameter DEPTH, payload `prio_entry_t`, push/pop/level) for the storage.
- The top holds the FSM, GAP counter and output register.

## Test plan
- **Reset and singles:** after reset, check `out_valid`=0, `out_onehot`=0000, `level`=0, `in_ready`=1. Push value 2 → after 2 edges, out_onehot=0100 and out_valid=1. With out_ready=1 → out_valid=0 the next cycle.
- **Full sweep:** push in_value 0,1,2,3 then in_none=1 with out_ready tied 1 and GAP=0 → grants 0001, 0010, 0100, 1000, 0000 in order, one every 2 cycles.
- **Backpressure/full:** out_ready=0 and push DEPTH+2 entries → `in_ready` falls once 1 entry is in GRANT and `level`=4. Extra pushes are ignored. Release out_ready → all 5 accepted grants drain in order, with none duplicated or lost.
- **Simultaneous push/pop at level 3:** `level` stays 3; the order across pointer wrap is preserved.
- **GAP=3:** consecutive grants are separated by exactly 4 cycles of out_valid=0.
- **Reset mid-GRANT with 3 entries queued:** rst for 1 cycle → out_valid=0 and level=0 the next cycle. No stale grant appears afterwards.
